// File: rtl/avalon_cmd_master_pkg.sv
// Shared types and widths for the Avalon command master toward the UART register slave.
package avalon_master_pkg;

    localparam int ADDR_WIDTH = 14;
    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        RSP
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] address;
        logic [BE_WIDTH-1:0]   byteenable;
        logic [DATA_WIDTH-1:0] writedata;
    } cmd_t;

endpackage

// File: rtl/avalon_cmd_master_if.sv
// Command stream, response stream and Avalon-MM bus of the command master.
interface avalon_cmd_master_if;
    import avalon_master_pkg::*;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_address_i;
    logic [BE_WIDTH-1:0]   cmd_byteenable_i;
    logic [DATA_WIDTH-1:0] cmd_writedata_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_readdata_o;
    logic                  rsp_timeout_o;
    logic                  spurious_o;

    logic [ADDR_WIDTH-1:0] address_o;
    logic [BE_WIDTH-1:0]   byteenable_o;
    logic                  write_o;
    logic [DATA_WIDTH-1:0] writedata_o;
    logic                  read_o;
    logic                  readdatavalid_i;
    logic [DATA_WIDTH-1:0] readdata_i;
    logic                  waitrequest_i;

    // The master modport is the command master itself.
    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_address_i, cmd_byteenable_i, cmd_writedata_i,
        input  rsp_ready_i, readdatavalid_i, readdata_i, waitrequest_i,
        output cmd_ready_o, rsp_valid_o, rsp_readdata_o, rsp_timeout_o, spurious_o,
        output address_o, byteenable_o, write_o, writedata_o, read_o
    );

    // The slave modport is everything around it: command source, response sink, UART slave.
    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_address_i, cmd_byteenable_i, cmd_writedata_i,
        output rsp_ready_i, readdatavalid_i, readdata_i, waitrequest_i,
        input  cmd_ready_o, rsp_valid_o, rsp_readdata_o, rsp_timeout_o, spurious_o,
        input  address_o, byteenable_o, write_o, writedata_o, read_o
    );

endinterface

// File: rtl/avalon_cmd_master_timeout_cnt.sv
// Read-wait cycle counter; expired is high while the count sits on its last value.
module avalon_timeout_cnt #(
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int CW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/avalon_cmd_master.sv
// Turns a valid/ready command stream into single-beat Avalon reads/writes, one outstanding.
//
//   state   | meaning
//   IDLE    | ready for a command
//   WR_REQ  | write_o asserted until waitrequest_i low
//   RD_REQ  | read_o asserted until waitrequest_i low
//   RD_WAIT | waiting for readdatavalid_i or timeout
//   RSP     | read response held until rsp_ready_i
module avalon_cmd_master
    import avalon_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    avalon_cmd_master_if.master bus
);

    state_t                state;
    state_t                state_nxt;
    cmd_t                  cmd_in;
    cmd_t                  cmd_r;
    logic                  cmd_ready_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic                  rsp_timeout_r;
    logic                  spurious_r;
    logic                  rd_accept;
    logic                  rd_capture;
    logic                  rd_expire;
    logic                  cnt_expired;

    assign cmd_in = {bus.cmd_write_i, bus.cmd_address_i, bus.cmd_byteenable_i, bus.cmd_writedata_i};

    assign rd_accept  = (state == RD_REQ) && !bus.waitrequest_i;
    assign rd_capture = bus.readdatavalid_i && (rd_accept || (state == RD_WAIT));
    assign rd_expire  = (state == RD_WAIT) && cnt_expired && !bus.readdatavalid_i;

    avalon_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (rd_accept),
        .enable (state == RD_WAIT),
        .expired(cnt_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_ready_r && bus.cmd_valid_i) begin
                    state_nxt = bus.cmd_write_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (!bus.waitrequest_i) begin
                    state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                if (rd_accept) begin
                    state_nxt = bus.readdatavalid_i ? RSP : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_capture || rd_expire) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // cmd_ready is a flop rather than a state decode so it stays low while reset is held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_ready_r   <= 1'b0;
            cmd_r         <= '0;
            rsp_data_r    <= '0;
            rsp_timeout_r <= 1'b0;
            spurious_r    <= 1'b0;
        end else begin
            cmd_ready_r <= (state_nxt == IDLE);
            spurious_r  <= bus.readdatavalid_i &&
                           ((state == IDLE) || (state == WR_REQ) || (state == RSP));
            if ((state == IDLE) && cmd_ready_r && bus.cmd_valid_i) begin
                cmd_r <= cmd_in;
            end
            if (rd_capture) begin
                rsp_data_r    <= bus.readdata_i;
                rsp_timeout_r <= 1'b0;
            end else if (rd_expire) begin
                rsp_data_r    <= '0;
                rsp_timeout_r <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready_o    = cmd_ready_r;
    assign bus.rsp_valid_o    = (state == RSP);
    assign bus.rsp_readdata_o = rsp_data_r;
    assign bus.rsp_timeout_o  = rsp_timeout_r;
    assign bus.spurious_o     = spurious_r;
    assign bus.write_o        = (state == WR_REQ) && cmd_r.write;
    assign bus.read_o         = (state == RD_REQ) && !cmd_r.write;
    assign bus.address_o      = cmd_r.address;
    assign bus.byteenable_o   = cmd_r.byteenable;
    assign bus.writedata_o    = cmd_r.writedata;

endmodule

// File: tb/tb_avalon_cmd_master.sv
// Self-checking bench for avalon_cmd_master: directed scenarios plus randomized traffic.
module tb_avalon_cmd_master;

    localparam int T = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    avalon_cmd_master_if bus();

    avalon_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid_i      = 1'b0;
        bus.cmd_write_i      = 1'b0;
        bus.cmd_address_i    = '0;
        bus.cmd_byteenable_i = '0;
        bus.cmd_writedata_i  = '0;
        bus.rsp_ready_i      = 1'b0;
        bus.readdatavalid_i  = 1'b0;
        bus.readdata_i       = '0;
        bus.waitrequest_i    = 1'b0;
    endtask

    // One write: expect write_o for nwait+1 cycles with the command's fields, then ready again.
    task automatic run_write(input logic [13:0] a, input logic [3:0] be,
                             input logic [31:0] d, input int nwait);
        n_cmp++;
        if (bus.cmd_ready_o !== 1'b1) begin
            n_err++; $display("FAIL wr_ready_pre got %b want 1", bus.cmd_ready_o);
        end
        bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b1; bus.cmd_address_i = a;
        bus.cmd_byteenable_i = be; bus.cmd_writedata_i = d; bus.waitrequest_i = (nwait > 0);
        tick();
        bus.cmd_valid_i = 1'b0; bus.cmd_address_i = ~a; bus.cmd_writedata_i = ~d;
        for (int i = 0; i <= nwait; i++) begin
            n_cmp++;
            if ({bus.write_o, bus.read_o, bus.cmd_ready_o, bus.rsp_valid_o} !== 4'b1000) begin
                n_err++; $display("FAIL wr_strobe cyc %0d got w%b r%b rdy%b rv%b want w1 r0 rdy0 rv0", i,
                                  bus.write_o, bus.read_o, bus.cmd_ready_o, bus.rsp_valid_o);
            end
            n_cmp++;
            if ({bus.address_o, bus.byteenable_o, bus.writedata_o} !== {a, be, d}) begin
                n_err++; $display("FAIL wr_bus cyc %0d got %h/%h/%h want %h/%h/%h", i,
                                  bus.address_o, bus.byteenable_o, bus.writedata_o, a, be, d);
            end
            bus.waitrequest_i = (i < nwait);
            tick();
        end
        bus.waitrequest_i = 1'b0;
        n_cmp++;
        if ({bus.write_o, bus.cmd_ready_o, bus.rsp_valid_o} !== 3'b010) begin
            n_err++; $display("FAIL wr_done got w%b rdy%b rv%b want w0 rdy1 rv0",
                              bus.write_o, bus.cmd_ready_o, bus.rsp_valid_o);
        end
    endtask

    // One read. lat = cycles after acceptance that readdatavalid comes (0 = same cycle);
    // the model says data is returned when lat <= T, otherwise a timeout with zero data.
    task automatic run_read(input logic [13:0] a, input logic [3:0] be, input int nwait,
                            input int lat, input logic [31:0] d, input int stall);
        logic        exp_to;
        logic [31:0] exp_d;
        exp_to = (lat > T);
        exp_d  = exp_to ? 32'h0 : d;
        n_cmp++;
        if (bus.cmd_ready_o !== 1'b1) begin
            n_err++; $display("FAIL rd_ready_pre got %b want 1", bus.cmd_ready_o);
        end
        bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_address_i = a;
        bus.cmd_byteenable_i = be; bus.cmd_writedata_i = $urandom; bus.waitrequest_i = (nwait > 0);
        tick();
        bus.cmd_valid_i = 1'b0; bus.cmd_address_i = ~a;
        for (int i = 0; i <= nwait; i++) begin
            n_cmp++;
            if ({bus.read_o, bus.write_o, bus.cmd_ready_o, bus.rsp_valid_o} !== 4'b1000) begin
                n_err++; $display("FAIL rd_strobe cyc %0d got r%b w%b rdy%b rv%b want r1 w0 rdy0 rv0", i,
                                  bus.read_o, bus.write_o, bus.cmd_ready_o, bus.rsp_valid_o);
            end
            n_cmp++;
            if ({bus.address_o, bus.byteenable_o} !== {a, be}) begin
                n_err++; $display("FAIL rd_bus cyc %0d got %h/%h want %h/%h", i,
                                  bus.address_o, bus.byteenable_o, a, be);
            end
            bus.waitrequest_i = (i < nwait);
            if (i == nwait && lat == 0) begin
                bus.readdatavalid_i = 1'b1; bus.readdata_i = d;
            end
            tick();
            bus.readdatavalid_i = 1'b0; bus.readdata_i = $urandom;
        end
        if (lat != 0) begin
            for (int k = 1; k <= T; k++) begin
                n_cmp++;
                if ({bus.read_o, bus.rsp_valid_o, bus.cmd_ready_o} !== 3'b000) begin
                    n_err++; $display("FAIL rd_wait k %0d got r%b rv%b rdy%b want all 0", k,
                                      bus.read_o, bus.rsp_valid_o, bus.cmd_ready_o);
                end
                bus.waitrequest_i = $urandom_range(0, 1);
                if (k == lat) begin
                    bus.readdatavalid_i = 1'b1; bus.readdata_i = d;
                end
                tick();
                bus.readdatavalid_i = 1'b0; bus.readdata_i = $urandom;
                if (k == lat) break;
            end
        end
        bus.waitrequest_i = $urandom_range(0, 1);
        for (int s = 0; s <= stall; s++) begin
            n_cmp++;
            if ({bus.rsp_valid_o, bus.cmd_ready_o} !== 2'b10) begin
                n_err++; $display("FAIL rsp_valid s %0d got rv%b rdy%b want rv1 rdy0", s,
                                  bus.rsp_valid_o, bus.cmd_ready_o);
            end
            n_cmp++;
            if ({bus.rsp_timeout_o, bus.rsp_readdata_o} !== {exp_to, exp_d}) begin
                n_err++; $display("FAIL rsp_data s %0d got to%b %h want to%b %h", s,
                                  bus.rsp_timeout_o, bus.rsp_readdata_o, exp_to, exp_d);
            end
            bus.rsp_ready_i = (s == stall);
            tick();
        end
        bus.rsp_ready_i   = 1'b0;
        bus.waitrequest_i = 1'b0;
        n_cmp++;
        if ({bus.rsp_valid_o, bus.cmd_ready_o, bus.spurious_o} !== 3'b010) begin
            n_err++; $display("FAIL rd_done got rv%b rdy%b sp%b want rv0 rdy1 sp0",
                              bus.rsp_valid_o, bus.cmd_ready_o, bus.spurious_o);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        n_cmp++;
        if ({bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_timeout_o, bus.rsp_readdata_o, bus.spurious_o,
             bus.read_o, bus.write_o, bus.address_o, bus.byteenable_o, bus.writedata_o} !== '0) begin
            n_err++; $display("FAIL reset_outputs got rdy%b rv%b r%b w%b addr %h want all 0",
                              bus.cmd_ready_o, bus.rsp_valid_o, bus.read_o, bus.write_o, bus.address_o);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.cmd_ready_o !== 1'b1) begin
            n_err++; $display("FAIL reset_release_ready got %b want 1", bus.cmd_ready_o);
        end
    endtask

    task automatic test_write();
        run_write(14'h0004, 4'hF, 32'hDEADBEEF, 0);
    endtask

    task automatic test_write_wait();
        run_write(14'h0123, 4'h3, 32'hCAFEF00D, 3);
    endtask

    task automatic test_read();
        run_read(14'h0008, 4'hF, 0, 2, 32'h0000_0055, 2);
    endtask

    task automatic test_timeout();
        run_read(14'h000C, 4'hF, 0, T + 5, 32'hAAAA5555, 0);
        tick();
        tick();
        bus.readdatavalid_i = 1'b1; bus.readdata_i = 32'hBADBAD00;
        tick();
        bus.readdatavalid_i = 1'b0;
        n_cmp++;
        if ({bus.spurious_o, bus.rsp_valid_o, bus.cmd_ready_o} !== 3'b101) begin
            n_err++; $display("FAIL late_spurious got sp%b rv%b rdy%b want sp1 rv0 rdy1",
                              bus.spurious_o, bus.rsp_valid_o, bus.cmd_ready_o);
        end
        tick();
        n_cmp++;
        if ({bus.spurious_o, bus.rsp_valid_o} !== 2'b00) begin
            n_err++; $display("FAIL late_pulse_end got sp%b rv%b want sp0 rv0",
                              bus.spurious_o, bus.rsp_valid_o);
        end
        run_read(14'h0020, 4'h1, 1, T, 32'h0BADF00D, 0);
        run_read(14'h0024, 4'h2, 0, T + 1, 32'h11112222, 1);
    endtask

    task automatic test_same_cycle();
        run_read(14'h0010, 4'hF, 1, 0, 32'h12345678, 0);
    endtask

    task automatic test_reset_mid();
        bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_address_i = 14'h0030;
        bus.cmd_byteenable_i = 4'hF; bus.waitrequest_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        n_cmp++;
        if (bus.read_o !== 1'b1) begin
            n_err++; $display("FAIL rstmid_read_pre got %b want 1", bus.read_o);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.read_o, bus.write_o, bus.cmd_ready_o, bus.rsp_valid_o} !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_drop got r%b w%b rdy%b rv%b want all 0",
                              bus.read_o, bus.write_o, bus.cmd_ready_o, bus.rsp_valid_o);
        end
        tick();
        rst = 1'b0;
        bus.waitrequest_i = 1'b0;
        tick();
        n_cmp++;
        if ({bus.cmd_ready_o, bus.rsp_valid_o} !== 2'b10) begin
            n_err++; $display("FAIL rstmid_release got rdy%b rv%b want rdy1 rv0",
                              bus.cmd_ready_o, bus.rsp_valid_o);
        end
        run_write(14'h0040, 4'hC, 32'h5A5AA5A5, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                run_write(14'($urandom), 4'($urandom), $urandom, $urandom_range(0, 3));
            end else begin
                run_read(14'($urandom), 4'($urandom), $urandom_range(0, 2),
                         $urandom_range(0, T + 3), $urandom, $urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_write_wait();
        test_read();
        test_timeout();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/avalon_cmd_master.md
Name: avalon_cmd_master

Overview:
- Avalon-MM master that turns a simple valid/ready command stream into single-beat Avalon reads and writes toward the UART register slave (14-bit address, 32-bit data, waitrequest, readdatavalid).
- Sits directly upstream of the UART's Avalon slave port. Lets a CPU-less test harness or a control FSM access UART registers without Avalon timing knowledge.
- Read results are returned on a valid/ready response stream. At most one transaction is outstanding at any time.

Parameters:
ADDR_WIDTH, 14, Avalon word address width
DATA_WIDTH, 32, data width; byteenable width = DATA_WIDTH/8
TIMEOUT_CYCLES, 256, max cycles waited in RD_WAIT for readdatavalid_i before flagging timeout (>=2)

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready at rising edge
cmd_write_i  in  1  1=write, 0=read
cmd_address_i  in  ADDR_WIDTH  target address
cmd_byteenable_i  in  DATA_WIDTH/8  byte lanes
cmd_writedata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  read response present
rsp_ready_i  in  1  response consumed when valid&ready
rsp_readdata_o  out  DATA_WIDTH  read data (0 on timeout)
rsp_timeout_o  out  1  response is a timeout, qualified by rsp_valid_o
spurious_o  out  1  one-cycle pulse: readdatavalid_i seen outside RD_REQ/RD_WAIT
address_o  out  ADDR_WIDTH  Avalon address
byteenable_o  out  DATA_WIDTH/8  Avalon byteenable
write_o  out  1  Avalon write
writedata_o  out  DATA_WIDTH  Avalon writedata
read_o  out  1  Avalon read
readdatavalid_i  in  1  Avalon read data valid
readdata_i  in  DATA_WIDTH  Avalon read data
waitrequest_i  in  1  Avalon stall

Behaviour:
- Reset (async, rst_i=1): state=IDLE. All outputs 0: cmd_ready_o, rsp_valid_o, rsp_timeout_o, rsp_readdata_o, spurious_o, read_o, write_o, address_o, byteenable_o, writedata_o. Timeout counter=0.
- Reset mid-transaction aborts immediately: read_o/write_o drop asynchronously and no response is produced.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch address, byteenable, writedata; go to WR_REQ if cmd_write_i=1, else RD_REQ.
- WR_REQ:
  - write_o=1; address/byteenable/writedata driven from the latched command and held stable.
  - On a rising edge with waitrequest_i=0: write accepted, go to IDLE.
  - Writes produce no response.
  - Latency: cmd accepted at edge N, write_o high during cycle N+1, cmd_ready_o high again in N+2 when there is no wait.
- RD_REQ:
  - read_o=1; address/byteenable held stable.
  - On waitrequest_i=0: go to RD_WAIT and clear the counter.
  - If readdatavalid_i=1 in the same cycle as acceptance: capture readdata_i and go directly to RSP.
- RD_WAIT:
  - read_o=0; counter increments each cycle.
  - readdatavalid_i=1: capture readdata_i, rsp_timeout_o=0, go to RSP.
  - Counter reaching TIMEOUT_CYCLES-1 without readdatavalid_i: rsp_readdata_o=0, rsp_timeout_o=1, go to RSP.
  - readdatavalid_i on the expiry cycle wins over the timeout.
- RSP:
  - rsp_valid_o=1; data and flag held stable until rsp_ready_i=1 at a rising edge, then go to IDLE.
  - cmd_ready_o=0 in every state except IDLE.
- readdatavalid_i in IDLE, WR_REQ or RSP (e.g. a late reply after a timeout): data discarded, spurious_o pulses 1 cycle, state unchanged.
- waitrequest_i is ignored while read_o=0 and write_o=0.

Decomposition:
- Package avalon_master_pkg:
  - state enum {IDLE, WR_REQ, RD_REQ, RD_WAIT, RSP};
  - packed struct cmd_t {write, address, byteenable, writedata};
  - localparam BE_WIDTH = DATA_WIDTH/8.
- One sub-module, avalon_timeout_cnt: clear/enable inputs, expired output, parameter TIMEOUT_CYCLES, counter width $clog2(TIMEOUT_CYCLES).

Test Plan:
1. Write addr 0x0004, data 0xDEADBEEF, be 0xF, waitrequest_i=0 -> write_o high exactly 1 cycle with those values; cmd_ready_o back 2 cycles after acceptance; no rsp_valid_o.
2. Write with waitrequest_i=1 for 3 cycles -> write_o high 4 cycles, address/data stable throughout, completes on the first low-waitrequest edge.
3. Read addr 0x0008; slave returns 0x00000055 two cycles after acceptance; rsp_ready_i=0 for 2 cycles -> rsp_valid_o held with data 0x55 and timeout 0 until ready; then IDLE.
4. Read with no readdatavalid_i, TIMEOUT_CYCLES=8 -> rsp_valid_o=1, rsp_timeout_o=1, rsp_readdata_o=0 after 8 RD_WAIT cycles; a late readdatavalid_i 3 cycles later -> spurious_o 1-cycle pulse, no second response.
5. Read where readdatavalid_i=1 on the same cycle waitrequest_i=0 (data 0x12345678) -> RSP the next cycle with that data.
6. Assert rst_i while read_o=1 under waitrequest -> read_o, cmd_ready_o, rsp_valid_o drop immediately; after release, cmd_ready_o=1 and a new write completes normally.
